// File: rtl/vga_frame_scheduler_if.sv
// Pixel stream bundle between two pixel sources, the frame scheduler and the
// VGA sync core's stream input.
interface vga_frame_scheduler_if #(
  parameter int CD = 12
);
  // Handshake: a pixel moves on a rising clk edge where valid & ready are both
  // high. Data follows valid and holds while ready is low. A producer may
  // withdraw valid between pixels. Ready can depend combinationally on valid.
  logic [CD-1:0] src0_data;
  logic          src0_valid;
  logic          src0_ready;
  logic [CD-1:0] src1_data;
  logic          src1_valid;
  logic          src1_ready;
  logic [CD:0]   out_data;
  logic          out_valid;
  logic          out_ready;

  // master: the scheduler, which consumes both sources and drives the output.
  modport master (
    input  src0_data, src0_valid,
    output src0_ready,
    input  src1_data, src1_valid,
    output src1_ready,
    output out_data, out_valid,
    input  out_ready
  );

  // slave: the surroundings, meaning the two sources and the sync-core sink.
  modport slave (
    output src0_data, src0_valid,
    input  src0_ready,
    output src1_data, src1_valid,
    input  src1_ready,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/vga_frame_scheduler.sv
// Frame-level source scheduler in front of the VGA sync core. It chooses src0,
// src1 or a constant background, switches only at frame boundaries and marks
// pixel (0,0) with the sof bit.
module vga_frame_scheduler #(
  parameter int CD = 12,
  parameter int HD = 640,
  parameter int VD = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            sel_req,
  input  logic [CD-1:0]         bg_color,
  vga_frame_scheduler_if.master bus,
  output logic [1:0]            cur_sel,
  output logic                  frame_done,
  output logic [9:0]            x_pos,
  output logic [8:0]            y_pos,
  output logic                  dbg_state
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [9:0] X_LAST = 10'(HD - 1);
  localparam logic [8:0] Y_LAST = 9'(VD - 1);

  logic [0:0]    state_q, state_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [1:0]    cur_sel_q, cur_sel_d;
  logic          frame_done_q, frame_done_d;

  logic [CD-1:0] colour;
  logic          out_valid;
  logic          src0_ready;
  logic          src1_ready;
  logic          sof;
  logic          transfer;

  // Zero-latency datapath: the selected source feeds the output directly.
  always_comb begin
    colour     = bg_color;
    out_valid  = 1'b0;
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    if (state_q == ST_ACTIVE) begin
      case (cur_sel_q)
        2'd0: begin
          out_valid  = bus.src0_valid;
          colour     = bus.src0_data;
          src0_ready = bus.out_ready;
        end
        2'd1: begin
          out_valid  = bus.src1_valid;
          colour     = bus.src1_data;
          src1_ready = bus.out_ready;
        end
        default: begin
          out_valid = 1'b1;
          colour    = bg_color;
        end
      endcase
    end
  end

  assign sof      = (state_q == ST_ACTIVE) && (x_q == 10'd0) && (y_q == 9'd0);
  assign transfer = out_valid & bus.out_ready;

  // Position advances only on accepted pixels. Selection and enable are
  // re-sampled only when the last pixel of a frame is accepted.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cur_sel_d    = cur_sel_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_ACTIVE;
          cur_sel_d = sel_req;
          x_d       = '0;
          y_d       = '0;
        end
      end
      default: begin
        if (transfer) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d          = '0;
              frame_done_d = 1'b1;
              cur_sel_d    = sel_req;
              if (!en) begin
                state_d = ST_IDLE;
              end
            end else begin
              y_d = y_q + 9'd1;
            end
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cur_sel_q    <= 2'd2;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cur_sel_q    <= cur_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.out_data   = {colour, sof};
  assign bus.out_valid  = out_valid;
  assign bus.src0_ready = src0_ready;
  assign bus.src1_ready = src1_ready;
  assign cur_sel        = cur_sel_q;
  assign frame_done     = frame_done_q;
  assign x_pos          = x_q;
  assign y_pos          = y_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench for vga_frame_scheduler on a reduced 8x4 frame. A frame-level pixel
// index model is checked against the DUT every cycle, alongside literal anchors.
module tb_vga_frame_scheduler;
  localparam int CD = 12;
  localparam int HD = 8;
  localparam int VD = 4;
  localparam int NPIX = HD * VD;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    sel_req = 2'd0;
  logic [CD-1:0] bg_color = '0;
  logic [1:0]    cur_sel;
  logic          frame_done;
  logic [9:0]    x_pos;
  logic [8:0]    y_pos;
  logic          dbg_state;

  always #5 clk = ~clk;

  vga_frame_scheduler_if #(.CD(CD)) bus ();

  vga_frame_scheduler #(.CD(CD), .HD(HD), .VD(VD)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sel_req    (sel_req),
    .bg_color   (bg_color),
    .bus        (bus),
    .cur_sel    (cur_sel),
    .frame_done (frame_done),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .dbg_state  (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- source drivers ----------------
  logic [CD-1:0] exp0_q[$];
  logic [CD-1:0] exp1_q[$];
  logic [CD-1:0] d0 = 12'h100;
  logic [CD-1:0] d1 = 12'h800;
  bit            gaps = 1'b0;
  bit            acc0 = 1'b0;
  bit            acc1 = 1'b0;

  initial begin
    bus.src0_data  = d0;
    bus.src1_data  = d1;
    bus.src0_valid = 1'b1;
    bus.src1_valid = 1'b1;
    bus.out_ready  = 1'b1;
    exp0_q.push_back(d0);
    exp1_q.push_back(d1);
  end

  always @(posedge clk) begin
    #1;
    if (acc0) begin
      d0 = d0 + 12'd1;
      bus.src0_data = d0;
      exp0_q.push_back(d0);
    end
    if (acc1) begin
      d1 = d1 + 12'd1;
      bus.src1_data = d1;
      exp1_q.push_back(d1);
    end
    bus.src0_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    bus.out_ready  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // ---------------- frame model + compare ----------------
  // The model tracks only "active?", "which source", and the linear pixel
  // index within the frame. Position follows from index arithmetic.
  bit       m_active = 1'b0;
  int       m_p = 0;
  int       m_sel = 2;
  bit       m_fd = 1'b0;
  int       m_frame_cnt = 0;
  int       m_last_len = 0;

  always @(negedge clk) begin
    logic          e_valid;
    logic [CD-1:0] e_col;
    logic          xfer;
    if (reset) begin
      m_active = 1'b0; m_p = 0; m_sel = 2; m_fd = 1'b0; m_frame_cnt = 0;
      acc0 = 1'b0; acc1 = 1'b0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_src0_ready", 32'(bus.src0_ready), 32'd0);
      chk("rst_src1_ready", 32'(bus.src1_ready), 32'd0);
      chk("rst_x", 32'(x_pos), 32'd0);
      chk("rst_y", 32'(y_pos), 32'd0);
      chk("rst_cur_sel", 32'(cur_sel), 32'd2);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
    end else begin
      e_valid = m_active && ((m_sel == 0) ? bus.src0_valid :
                             (m_sel == 1) ? bus.src1_valid : 1'b1);
      e_col   = (m_sel == 0) ? bus.src0_data : (m_sel == 1) ? bus.src1_data : bg_color;
      chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
      chk("src0_ready", 32'(bus.src0_ready), 32'(m_active && m_sel == 0 && bus.out_ready));
      chk("src1_ready", 32'(bus.src1_ready), 32'(m_active && m_sel == 1 && bus.out_ready));
      chk("cur_sel", 32'(cur_sel), 32'(m_sel));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("x_pos", 32'(x_pos), 32'(m_p % HD));
      chk("y_pos", 32'(y_pos), 32'(m_p / HD));
      if (m_active) begin
        chk("sof", 32'(bus.out_data[0]), 32'(m_p == 0));
        chk("colour", 32'(bus.out_data[CD:1]), 32'(e_col));
      end
      xfer = m_active && e_valid && bus.out_ready;
      acc0 = xfer && m_sel == 0;
      acc1 = xfer && m_sel == 1;
      if (acc0) begin
        if (exp0_q.size() == 0) fail_now("src0_queue_empty");
        else chk("src0_order", 32'(bus.out_data[CD:1]), 32'(exp0_q.pop_front()));
      end
      if (acc1) begin
        if (exp1_q.size() == 0) fail_now("src1_queue_empty");
        else chk("src1_order", 32'(bus.out_data[CD:1]), 32'(exp1_q.pop_front()));
      end
      m_fd = 1'b0;
      if (!m_active) begin
        if (en) begin
          m_active = 1'b1; m_sel = int'(sel_req); m_p = 0; m_frame_cnt = 0;
        end
      end else if (xfer) begin
        m_frame_cnt++;
        if (m_p == NPIX - 1) begin
          m_p = 0; m_fd = 1'b1; m_sel = int'(sel_req);
          m_last_len = m_frame_cnt; m_frame_cnt = 0;
          if (!en) m_active = 1'b0;
        end else begin
          m_p++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Returns on the negedge where frame_done is high.
  task automatic wait_fd(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now(name);
  endtask

  // Returns #1 after the posedge on which pixel index tgt is presented.
  task automatic wait_pix(input int tgt, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (m_active && m_p == tgt) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    if (!seen) fail_now(name);
  endtask

  task automatic to_drive_point();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_cur_sel", 32'(cur_sel), 32'd2);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    to_drive_point();

    // Full src0 frame. The next pixel must be sof.
    sel_req = 2'd0;
    en = 1'b1;
    wait_fd(200, "fd_frame1");
    chk("f1_next_sof", 32'(bus.out_data[0]), 32'd1);
    chk("f1_next_xy", 32'({y_pos, x_pos}), 32'd0);
    to_drive_point();
    chk("f1_len", 32'(m_last_len), 32'(NPIX));

    // Switch request mid-frame takes effect only at the boundary.
    wait_pix(2 * HD + 3, 200, "pix_3_2");
    sel_req = 2'd1;
    wait_fd(200, "fd_frame2");
    chk("f2_cur_sel", 32'(cur_sel), 32'd1);
    chk("f2_src1_first", 32'(bus.out_data), 32'({12'h800, 1'b1}));
    to_drive_point();

    // Background frame follows the src1 frame.
    sel_req = 2'd2;
    bg_color = 12'hF00;
    wait_fd(200, "fd_frame3");
    chk("bg_first_pixel", 32'(bus.out_data), 32'h1E01);
    chk("bg_valid", 32'(bus.out_valid), 32'd1);
    chk("bg_src0_ready", 32'(bus.src0_ready), 32'd0);
    to_drive_point();

    // src0 with random valid and ready gaps for two frames.
    sel_req = 2'd0;
    gaps = 1'b1;
    wait_fd(200, "fd_frame4");
    to_drive_point();
    wait_fd(2000, "fd_frame5");
    to_drive_point();
    chk("gap_frame_len", 32'(m_last_len), 32'(NPIX));
    wait_fd(2000, "fd_frame6");
    to_drive_point();
    gaps = 1'b0;

    // Drop enable mid-frame. The frame completes, then IDLE.
    wait_pix(2 * HD + 5, 2000, "pix_5_2");
    en = 1'b0;
    wait_fd(200, "fd_frame7");
    chk("stop_out_valid", 32'(bus.out_valid), 32'd0);
    chk("stop_state", 32'(dbg_state), 32'd0);
    repeat (4) to_drive_point();

    // Reset mid-frame, then restart.
    en = 1'b1;
    wait_pix(2 * HD + 4, 200, "pix_4_2");
    reset = 1'b1;
    #1;
    chk("arst_x", 32'(x_pos), 32'd0);
    chk("arst_y", 32'(y_pos), 32'd0);
    chk("arst_cur_sel", 32'(cur_sel), 32'd2);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_src0_ready", 32'(bus.src0_ready), 32'd0);
    to_drive_point();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dbg_state === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("restart_active");
    else chk("restart_sof", 32'(bus.out_data[0]), 32'd1);
    wait_fd(200, "fd_after_reset");
    to_drive_point();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
